// File: rtl/instr_fetch_decode.sv
// Multi-cycle fetch/decode sequencer for a 16-bit program memory that drives an
// external 8-bit ALU and writes its result back into a four-entry register file.
module instr_fetch_decode #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [15:0]       prog_data,
  output logic [7:0]        a,
  output logic [7:0]        b,
  output logic [2:0]        opcode,
  output logic              issue_valid,
  input  logic              wb_valid,
  input  logic [7:0]        wb_data,
  input  logic              wb_carry,
  output logic              carry_flag,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    ISSUE,
    WAIT,
    HALT
  } state_t;

  state_t      state;
  logic [15:0] ir;
  logic [7:0]  regs [4];
  logic [15:0] mem  [2**ADDR_W];

  logic [1:0]  ra, rb, rd_alu, rd_ldi;
  logic [7:0]  imm;

  assign ra     = ir[11:10];
  assign rb     = ir[9:8];
  assign rd_alu = ir[7:6];
  assign rd_ldi = ir[9:8];
  assign imm    = ir[7:0];

  // Program memory has no reset so a loaded program survives rst.
  always_ff @(posedge clk) begin
    if (state == IDLE && prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ir          <= '0;
      pc          <= '0;
      a           <= '0;
      b           <= '0;
      opcode      <= '0;
      issue_valid <= 1'b0;
      carry_flag  <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pc    <= '0;
            busy  <= 1'b1;
            state <= FETCH;
          end
        end

        FETCH: begin
          ir    <= mem[pc];
          state <= DECODE;
        end

        DECODE: begin
          if (ir[15:14] == 2'b11) begin
            busy   <= 1'b0;
            halted <= 1'b1;
            state  <= HALT;
          end else if (ir[15]) begin
            regs[rd_ldi] <= imm;
            pc           <= pc + 1'b1;
            state        <= FETCH;
          end else begin
            a           <= regs[ra];
            b           <= regs[rb];
            opcode      <= ir[14:12];
            issue_valid <= 1'b1;
            state       <= ISSUE;
          end
        end

        ISSUE: begin
          issue_valid <= 1'b0;
          state       <= WAIT;
        end

        WAIT: begin
          if (wb_valid) begin
            regs[rd_alu] <= wb_data;
            carry_flag   <= wb_carry;
            pc           <= pc + 1'b1;
            state        <= FETCH;
          end
        end

        HALT: begin
          if (start) begin
            pc     <= '0;
            busy   <= 1'b1;
            halted <= 1'b0;
            state  <= FETCH;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Bench for instr_fetch_decode: an instruction-level reference model predicts
// operands, pc and flags while the bench plays the external ALU.
module tb_instr_fetch_decode;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [15:0]   prog_data = '0;
  logic [7:0]    a, b;
  logic [2:0]    opcode;
  logic          issue_valid;
  logic          wb_valid = 1'b0;
  logic [7:0]    wb_data = '0;
  logic          wb_carry = 1'b0;
  logic          carry_flag;
  logic [AW-1:0] pc;
  logic          busy, halted;

  always #5 clk = ~clk;

  instr_fetch_decode #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .a          (a),
    .b          (b),
    .opcode     (opcode),
    .issue_valid(issue_valid),
    .wb_valid   (wb_valid),
    .wb_data    (wb_data),
    .wb_carry   (wb_carry),
    .carry_flag (carry_flag),
    .pc         (pc),
    .busy       (busy),
    .halted     (halted)
  );

  // Reference model: architectural state only.
  logic [15:0] prog  [DEPTH];
  logic [15:0] m_mem [DEPTH];
  logic [7:0]  m_reg [4];
  logic        m_carry;
  int          m_pc;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_pc"},     32'(pc), 0);
    check({tag, "_a"},      32'(a), 0);
    check({tag, "_b"},      32'(b), 0);
    check({tag, "_op"},     32'(opcode), 0);
    check({tag, "_issue"},  32'(issue_valid), 0);
    check({tag, "_carry"},  32'(carry_flag), 0);
    check({tag, "_busy"},   32'(busy), 0);
    check({tag, "_halted"}, 32'(halted), 0);
  endtask

  // Asynchronous reset asserted between clock edges and checked before any edge.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_idle("async_rst");
    for (int i = 0; i < 4; i++) m_reg[i] = '0;
    m_carry = 1'b0;
    m_pc    = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Writes prog[] into memory; the final write coincides with start.
  task automatic load_and_start();
    for (int i = 0; i < DEPTH; i++) begin
      prog_we   = 1'b1;
      prog_addr = AW'(i);
      prog_data = prog[i];
      m_mem[i]  = prog[i];
      if (i == DEPTH - 1) start = 1'b1;
      @(negedge clk);
    end
    prog_we = 1'b0;
    start   = 1'b0;
    m_pc    = 0;
  endtask

  task automatic start_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_pc  = 0;
  endtask

  function automatic logic [8:0] alu(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
    logic [8:0] r;
    case (op)
      3'd0:    r = {1'b0, x} + {1'b0, y};
      3'd1:    r = {(x >= y), 8'(x - y)};
      default: r = 9'($urandom);
    endcase
    return r;
  endfunction

  // Runs from FETCH; hold < 0 picks a random WAIT stall length.
  task automatic run_prog(input int max_instr, input int hold, output bit halted_seen);
    logic [15:0] ins;
    logic [8:0]  res;
    int          stall;
    halted_seen = 1'b0;
    for (int n = 0; n < max_instr; n++) begin
      ins = m_mem[m_pc];
      check("fetch_pc", 32'(pc), 32'(m_pc));
      check("fetch_busy", 32'(busy), 1);
      @(negedge clk);
      if (ins[15:14] == 2'b11) begin
        @(negedge clk);
        check("halt_flag", 32'(halted), 1);
        check("halt_busy", 32'(busy), 0);
        check("halt_pc", 32'(pc), 32'(m_pc));
        halted_seen = 1'b1;
        return;
      end else if (ins[15]) begin
        m_reg[ins[9:8]] = ins[7:0];
        m_pc = (m_pc + 1) % DEPTH;
        @(negedge clk);
      end else begin
        @(negedge clk);
        check("issue_valid", 32'(issue_valid), 1);
        check("issue_a", 32'(a), 32'(m_reg[ins[11:10]]));
        check("issue_b", 32'(b), 32'(m_reg[ins[9:8]]));
        check("issue_op", 32'(opcode), 32'(ins[14:12]));
        res = alu(ins[14:12], m_reg[ins[11:10]], m_reg[ins[9:8]]);
        if ($urandom_range(1, 0) == 1) begin
          wb_valid = 1'b1;
          wb_data  = 8'($urandom);
          wb_carry = 1'($urandom);
        end
        @(negedge clk);
        wb_valid = 1'b0;
        check("wait_issue_low", 32'(issue_valid), 0);
        stall = (hold >= 0) ? hold : int'($urandom_range(3, 0));
        for (int h = 0; h < stall; h++) begin
          prog_we   = 1'($urandom);
          prog_addr = AW'($urandom);
          prog_data = 16'($urandom);
          start     = 1'($urandom);
          @(negedge clk);
          prog_we = 1'b0;
          start   = 1'b0;
          check("stall_issue", 32'(issue_valid), 0);
          check("stall_pc", 32'(pc), 32'(m_pc));
          check("stall_busy", 32'(busy), 1);
        end
        wb_valid = 1'b1;
        wb_data  = res[7:0];
        wb_carry = res[8];
        @(negedge clk);
        wb_valid = 1'b0;
        m_reg[ins[7:6]] = res[7:0];
        m_carry = res[8];
        m_pc = (m_pc + 1) % DEPTH;
        check("wb_carry_flag", 32'(carry_flag), 32'(m_carry));
      end
    end
  endtask

  function automatic logic [15:0] rand_instr();
    if ($urandom_range(2, 0) == 0)
      return {2'b10, 4'($urandom), 2'($urandom), 8'($urandom)};
    return {1'b0, 3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 6'($urandom)};
  endfunction

  initial begin
    bit hs;
    int len;

    for (int i = 0; i < 4; i++) m_reg[i] = '0;
    m_carry = 1'b0;
    m_pc    = 0;
    #2 rst = 1'b0;
    #1 check_idle("power_rst");
    @(negedge clk);
    rst = 1'b1;

    // ADD of two loaded immediates
    for (int i = 0; i < DEPTH; i++) prog[i] = 16'hC000;
    prog[0] = 16'h8005; prog[1] = 16'h8103; prog[2] = 16'h0180; prog[3] = 16'hC000;
    load_and_start();
    run_prog(20, 0, hs);
    check("add_halted", 32'(hs), 1);
    check("add_pc", 32'(pc), 3);
    check("add_a_held", 32'(a), 8'h05);
    check("add_b_held", 32'(b), 8'h03);
    check("add_op_held", 32'(opcode), 0);

    // Writes while halted are dropped; rerun from HALT
    prog_we = 1'b1; prog_addr = AW'(2); prog_data = 16'hFFFF;
    @(negedge clk);
    prog_we = 1'b0;
    check("halt_stays", 32'(halted), 1);
    start_run();
    run_prog(20, -1, hs);
    check("rerun_halted", 32'(hs), 1);

    // SUB with a long writeback stall
    do_reset();
    for (int i = 0; i < DEPTH; i++) prog[i] = 16'hC000;
    prog[0] = 16'h80CC; prog[1] = 16'h81AA; prog[2] = 16'h1180;
    load_and_start();
    run_prog(20, 10, hs);
    check("sub_halted", 32'(hs), 1);
    check("sub_carry", 32'(carry_flag), 1);

    // Reset in the middle of WAIT, then a stray writeback
    do_reset();
    for (int i = 0; i < DEPTH; i++) prog[i] = 16'hC000;
    prog[0] = 16'h0180; prog[1] = 16'h805A; prog[2] = 16'h8121; prog[3] = 16'h11C0;
    load_and_start();
    run_prog(20, -1, hs);
    check("rw_first_halt", 32'(hs), 1);
    start_run();
    @(negedge clk);
    @(negedge clk);
    check("rw_issue", 32'(issue_valid), 1);
    check("rw_a_retained", 32'(a), 8'h5A);
    check("rw_b_retained", 32'(b), 8'h21);
    @(negedge clk);
    do_reset();
    wb_valid = 1'b1; wb_data = 8'hEE; wb_carry = 1'b1;
    @(negedge clk);
    wb_valid = 1'b0;
    @(negedge clk);
    check_idle("post_rst_wb");
    start_run();
    run_prog(20, -1, hs);
    check("rw_restart_halt", 32'(hs), 1);

    // Sixteen LDIs: pc must wrap and the machine keeps running
    do_reset();
    for (int i = 0; i < DEPTH; i++) prog[i] = {2'b10, 4'($urandom), 2'($urandom), 8'($urandom)};
    load_and_start();
    run_prog(40, -1, hs);
    check("wrap_no_halt", 32'(hs), 0);
    check("wrap_busy", 32'(busy), 1);

    // Random programs, each run twice to exercise register retention across HALT
    for (int t = 0; t < 6; t++) begin
      do_reset();
      len = int'($urandom_range(14, 3));
      for (int i = 0; i < DEPTH; i++) prog[i] = (i < len) ? rand_instr() : 16'hC000;
      load_and_start();
      run_prog(40, -1, hs);
      check("rand_halt1", 32'(hs), 1);
      start_run();
      run_prog(40, -1, hs);
      check("rand_halt2", 32'(hs), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
